// File: rtl/grn_node_param.sv
// -----------------------------------------------------------------------------
// grn_node_param
//   Boolean gene-regulatory-network node. Keeps a slow (s0) and a fast (s1)
//   copy of the node state for attractor detection; each copy is LANES bits
//   wide so LANES independent trajectories run bit-parallel.
//
//   The update rule is selected by MODE:
//     0 : any active activator AND no active inhibitor
//     1 : signed threshold, activators minus inhibitors; a zero score holds
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   reset_nos       load init_state into both copies, restart slow divider
//   start_s0        slow step strobe (acts on one of every SLOW_DIV pulses)
//   start_s1        fast step strobe (acts on every pulse)
//   init_state      per-lane initial state
//   act_mask        regulator i is an activator when bit i is set
//   inh_mask        regulator i is an inhibitor when bit i is set
//   in_s0 / in_s1   regulator states; bit [l*N_IN+i] = regulator i, lane l
//   s0 / s1         registered slow / fast state
//   s1_changed      one-cycle per-lane pulse after an s1 update flips a bit
//   match           registered s0==s1, one cycle behind s0/s1
// -----------------------------------------------------------------------------
module grn_node_param #(
  parameter int N_IN     = 4,
  parameter int LANES    = 1,
  parameter int SLOW_DIV = 2,
  parameter int MODE     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset_nos,
  input  logic                  start_s0,
  input  logic                  start_s1,
  input  logic [LANES-1:0]      init_state,
  input  logic [N_IN-1:0]       act_mask,
  input  logic [N_IN-1:0]       inh_mask,
  input  logic [N_IN*LANES-1:0] in_s0,
  input  logic [N_IN*LANES-1:0] in_s1,
  output logic [LANES-1:0]      s0,
  output logic [LANES-1:0]      s1,
  output logic [LANES-1:0]      s1_changed,
  output logic [LANES-1:0]      match
);

  // Score range is [-N_IN, N_IN]; one extra bit over the count width holds the sign.
  localparam int SCORE_W = $clog2(N_IN + 1) + 1;
  localparam int DIV_W   = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

  logic [LANES-1:0] r_s0;
  logic [LANES-1:0] r_s1;
  logic [LANES-1:0] r_chg;
  logic [LANES-1:0] r_match;
  logic [DIV_W-1:0] r_div;

  logic [LANES-1:0] w_nxt0;
  logic [LANES-1:0] w_nxt1;

  // Next state of one lane from its regulator vector x and its current bit.
  function automatic logic f_next(input logic [N_IN-1:0] x,
                                  input logic            cur);
    logic [SCORE_W-1:0]        pa;
    logic [SCORE_W-1:0]        pi;
    logic signed [SCORE_W-1:0] score;
    logic                      res;
    pa = '0;
    pi = '0;
    for (int i = 0; i < N_IN; i++) begin
      pa = pa + SCORE_W'(x[i] & act_mask[i]);
      pi = pi + SCORE_W'(x[i] & inh_mask[i]);
    end
    score = signed'(pa) - signed'(pi);
    if (MODE == 0) begin
      // A regulator set in both masks contributes to both terms.
      res = (|(x & act_mask)) & ~(|(x & inh_mask));
    end else if (score > 0) begin
      res = 1'b1;
    end else if (score < 0) begin
      res = 1'b0;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Combinational next-state for both copies, all lanes
  always_comb begin
    w_nxt0 = '0;
    w_nxt1 = '0;
    for (int l = 0; l < LANES; l++) begin
      w_nxt0[l] = f_next(in_s0[l*N_IN +: N_IN], r_s0[l]);
      w_nxt1[l] = f_next(in_s1[l*N_IN +: N_IN], r_s1[l]);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0    <= '0;
      r_s1    <= '0;
      r_chg   <= '0;
      r_match <= '1;
      r_div   <= '0;
    end else if (reset_nos) begin
      // Reload wins over any strobe in the same cycle.
      r_s0    <= init_state;
      r_s1    <= init_state;
      r_chg   <= '0;
      r_match <= '1;
      r_div   <= '0;
    end else begin
      // Compares the state as it stands now, so match trails s0/s1 by a cycle.
      r_match <= ~(r_s0 ^ r_s1);
      r_chg   <= '0;
      if (start_s0) begin
        if (r_div == '0) begin
          r_s0 <= w_nxt0;
        end
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end
      if (start_s1) begin
        r_s1  <= w_nxt1;
        r_chg <= r_s1 ^ w_nxt1;
      end
    end
  end

  assign s0         = r_s0;
  assign s1         = r_s1;
  assign s1_changed = r_chg;
  assign match      = r_match;

endmodule

// File: tb/tb_grn_node_param.sv
module tb_grn_node_param;

  localparam int N_IN  = 4;
  localparam int LANES = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  reset_nos = 1'b0;
  logic                  start_s0 = 1'b0;
  logic                  start_s1 = 1'b0;
  logic [LANES-1:0]      init_state = '0;
  logic [N_IN-1:0]       act_mask = '0;
  logic [N_IN-1:0]       inh_mask = '0;
  logic [N_IN*LANES-1:0] in_s0 = '0;
  logic [N_IN*LANES-1:0] in_s1 = '0;

  logic [LANES-1:0] a_s0, a_s1, a_chg, a_match;
  logic [LANES-1:0] b_s0, b_s1, b_chg, b_match;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = MODE0/SLOW_DIV=2, index 1 = MODE1/SLOW_DIV=3
  logic [LANES-1:0] m_s0 [2];
  logic [LANES-1:0] m_s1 [2];
  logic [LANES-1:0] m_chg [2];
  logic [LANES-1:0] m_match [2];
  int               m_div [2];

  always #5 clk = ~clk;

  grn_node_param #(.N_IN(N_IN), .LANES(LANES), .SLOW_DIV(2), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .start_s0(start_s0),
    .start_s1(start_s1), .init_state(init_state), .act_mask(act_mask),
    .inh_mask(inh_mask), .in_s0(in_s0), .in_s1(in_s1),
    .s0(a_s0), .s1(a_s1), .s1_changed(a_chg), .match(a_match));

  grn_node_param #(.N_IN(N_IN), .LANES(LANES), .SLOW_DIV(3), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .start_s0(start_s0),
    .start_s1(start_s1), .init_state(init_state), .act_mask(act_mask),
    .inh_mask(inh_mask), .in_s0(in_s0), .in_s1(in_s1),
    .s0(b_s0), .s1(b_s1), .s1_changed(b_chg), .match(b_match));

  // Rule straight from the definition: count active activators and inhibitors.
  function automatic logic mnext(input int mode, input logic [N_IN-1:0] x,
                                 input logic cur);
    int na, ni;
    na = $countones(x & act_mask);
    ni = $countones(x & inh_mask);
    if (mode == 0) return (na > 0) && (ni == 0);
    if (na > ni) return 1'b1;
    if (na < ni) return 1'b0;
    return cur;
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      logic [LANES-1:0] n0, n1, old0, old1;
      int div;
      div  = (d == 0) ? 2 : 3;
      old0 = m_s0[d];
      old1 = m_s1[d];
      for (int l = 0; l < LANES; l++) begin
        n0[l] = mnext(d, in_s0[l*N_IN +: N_IN], old0[l]);
        n1[l] = mnext(d, in_s1[l*N_IN +: N_IN], old1[l]);
      end
      if (rst) begin
        m_s0[d] = '0; m_s1[d] = '0; m_chg[d] = '0; m_match[d] = '1; m_div[d] = 0;
      end else if (reset_nos) begin
        m_s0[d] = init_state; m_s1[d] = init_state; m_chg[d] = '0;
        m_match[d] = '1; m_div[d] = 0;
      end else begin
        for (int l = 0; l < LANES; l++) m_match[d][l] = (old0[l] == old1[l]);
        m_chg[d] = '0;
        if (start_s0) begin
          if (m_div[d] == 0) m_s0[d] = n0;
          m_div[d] = (m_div[d] + 1) % div;
        end
        if (start_s1) begin
          m_s1[d]  = n1;
          m_chg[d] = old1 ^ n1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [LANES-1:0] act,
                     input logic [LANES-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("d0.s0", a_s0, m_s0[0]);   chk("d0.s1", a_s1, m_s1[0]);
    chk("d0.chg", a_chg, m_chg[0]); chk("d0.match", a_match, m_match[0]);
    chk("d1.s0", b_s0, m_s0[1]);   chk("d1.s1", b_s1, m_s1[1]);
    chk("d1.chg", b_chg, m_chg[1]); chk("d1.match", b_match, m_match[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic ctl(input logic r, input logic rn, input logic a, input logic b);
    rst = r; reset_nos = rn; start_s0 = a; start_s1 = b;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_s0[d] = 'x; m_s1[d] = 'x; m_chg[d] = 'x; m_match[d] = 'x; m_div[d] = 0;
    end
    #2;
    // T1: reset, then reload with a per-lane pattern
    ctl(1, 0, 0, 0);
    step();
    chk("rst.s0", a_s0, 4'b0000);
    chk("rst.match", a_match, 4'b1111);
    ctl(0, 1, 0, 0); init_state = 4'b1011;
    step();
    chk("t1.s0", a_s0, 4'b1011);
    chk("t1.s1", b_s1, 4'b1011);
    chk("t1.match", a_match, 4'b1111);
    chk("t1.chg", a_chg, 4'b0000);

    // T2: OR/AND-NOT rule on lane 0
    ctl(0, 0, 0, 1); act_mask = 4'b0011; inh_mask = 4'b0100;
    in_s1 = 16'h0001;
    step();
    chk("t2.s1_l0", {3'b000, a_s1[0]}, 4'b0001);
    in_s1 = 16'h0005;
    step();
    chk("t2.s1_l0_off", {3'b000, a_s1[0]}, 4'b0000);
    chk("t2.chg_l0", {3'b000, a_chg[0]}, 4'b0001);
    chk("t2.m1_hold", {3'b000, b_s1[0]}, 4'b0001);

    // T3: threshold rule, zero score holds
    act_mask = 4'b0111; inh_mask = 4'b1000;
    in_s1 = 16'h0008;
    step();
    chk("t3.neg", {3'b000, b_s1[0]}, 4'b0000);
    in_s1 = 16'h0009;
    step();
    chk("t3.zero_hold", {3'b000, b_s1[0]}, 4'b0000);
    in_s1 = 16'h000B;
    step();
    chk("t3.pos", {3'b000, b_s1[0]}, 4'b0001);
    ctl(0, 0, 0, 0);
    step();
    chk("t3.chg_clear", b_chg, 4'b0000);

    // T4: divide-by-2 slow path, inputs steer next toward ~s0
    ctl(0, 1, 0, 0); init_state = 4'b0000;
    act_mask = 4'b0001; inh_mask = 4'b0010;
    step();
    for (int p = 0; p < 4; p++) begin
      logic [LANES-1:0] expv;
      ctl(0, 0, 1, 0);
      for (int l = 0; l < LANES; l++) in_s0[l*N_IN +: N_IN] = {3'b000, ~m_s0[0][l]};
      step();
      expv = (p < 2) ? 4'b1111 : 4'b0000;
      chk("t4.div_s0", a_s0, expv);
    end

    // T6: reload beats simultaneous strobes
    ctl(0, 1, 1, 1); init_state = 4'b0110;
    in_s0 = 16'hFFFF; in_s1 = 16'h1111;
    step();
    chk("t6.s0", a_s0, 4'b0110);
    chk("t6.s1", b_s1, 4'b0110);
    chk("t6.chg", a_chg, 4'b0000);

    // Randomized run, with occasional reloads and resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        act_mask = 4'($urandom); inh_mask = 4'($urandom);
      end
      in_s0 = 16'($urandom); in_s1 = 16'($urandom);
      init_state = 4'($urandom);
      ctl($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
          1'($urandom), 1'($urandom));
      step();
    end

    // T6: reset mid-run
    ctl(0, 0, 1, 1); in_s1 = 16'hFFFF; act_mask = 4'b1111; inh_mask = 4'b0000;
    step();
    ctl(1, 0, 1, 1);
    step();
    chk("t6.rst_s0", a_s0, 4'b0000);
    chk("t6.rst_s1", b_s1, 4'b0000);
    chk("t6.rst_match", b_match, 4'b1111);
    chk("t6.rst_chg", a_chg, 4'b0000);
    ctl(0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
